// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO burst controller.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam int DATA_W  = 8;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1023;

endpackage

// File: rtl/stall_timer.sv
// Counts consecutive stalled cycles, saturating at TIMEOUT.
module stall_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired_o = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Sequences button fill/drain requests into FIFO write bursts and drains.
module fifo_burst_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W  = fifo_ctrl_pkg::DATA_W,
    parameter int LEN_W   = fifo_ctrl_pkg::LEN_W,
    parameter int CNT_W   = fifo_ctrl_pkg::CNT_W,
    parameter int TIMEOUT = fifo_ctrl_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic              drain_req,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              full,
    input  logic              empty,
    output logic              wr_en,
    output logic [DATA_W-1:0] din,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic              reject,
    output logic              err_timeout,
    output logic [LEN_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    localparam logic [CNT_W-1:0] RD_CAP = '1;

    ctrl_state_t       state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              err_q, err_d;
    logic              reject_q, reject_d;
    logic              stall_clr;
    logic              stall_cnt;
    logic              expired;
    logic              wr_left;

    stall_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_stall (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (stall_clr),
        .count_i  (stall_cnt),
        .expired_o(expired)
    );

    assign wr_left = (wr_cnt_q != len_q);

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        len_d     = len_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        din       = '0;
        done      = 1'b0;
        stall_clr = 1'b0;
        stall_cnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d   = FILL;
                    seed_d    = seed;
                    len_d     = burst_len;
                    wr_cnt_d  = '0;
                    err_d     = 1'b0;
                    stall_clr = 1'b1;
                end else if (drain_req) begin
                    state_d   = DRAIN;
                    rd_cnt_d  = '0;
                    err_d     = 1'b0;
                    stall_clr = 1'b1;
                end
            end
            FILL: begin
                // An expired timer blocks a late write in the abort cycle
                wr_en = ~full & wr_left & ~expired;
                din   = seed_q + DATA_W'(wr_cnt_q);
                if (wr_en) begin
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                    stall_clr = 1'b1;
                end else if (full && wr_left) begin
                    stall_cnt = 1'b1;
                end
                if (expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (wr_cnt_d == len_q) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                rd_en = ~empty & (rd_cnt_q != RD_CAP);
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (empty || rd_cnt_d == RD_CAP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign reject_d = (fill_req | drain_req) & (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            len_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
            reject_q <= reject_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign reject      = reject_q;
    assign err_timeout = err_q;
    assign wr_count    = wr_cnt_q;
    assign rd_count    = rd_cnt_q;

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed self-checking bench for fifo_burst_ctrl (TIMEOUT=16).
module tb_fifo_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fill_req;
    logic       drain_req;
    logic [7:0] seed;
    logic [4:0] burst_len;
    logic       full;
    logic       empty;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       busy;
    logic       done;
    logic       reject;
    logic       err_timeout;
    logic [4:0] wr_count;
    logic [7:0] rd_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_burst_ctrl #(
        .DATA_W (8),
        .LEN_W  (5),
        .CNT_W  (8),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .drain_req  (drain_req),
        .seed       (seed),
        .burst_len  (burst_len),
        .full       (full),
        .empty      (empty),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .busy       (busy),
        .done       (done),
        .reject     (reject),
        .err_timeout(err_timeout),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fill_req = 0; drain_req = 0;
        seed = 0; burst_len = 0; full = 0; empty = 1;
        step(); step();
        #1;
        checks++;
        if ({busy, done, reject, err_timeout, wr_en, rd_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, done, reject, err_timeout, wr_en, rd_en});
        end
        checks++;
        if ({din, wr_count, rd_count} !== 21'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0",
                     din, wr_count, rd_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp_din [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        seed = 8'hFE; burst_len = 5'd4; full = 0;
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (wr_en !== 1'b1 || din !== exp_din[i]) begin
                failures++;
                $display("FAIL fill_wrap_w%0d got=%b/%h exp=1/%h",
                         i, wr_en, din, exp_din[i]);
            end
            step();
        end
        #1;
        checks++;
        if (done !== 1'b1 || wr_en !== 1'b0 || wr_count !== 5'd4) begin
            failures++;
            $display("FAIL fill_wrap_done got=%b/%b/%0d exp=1/0/4",
                     done, wr_en, wr_count);
        end
        step();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL fill_wrap_idle got=%b/%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_fill_stall();
        int writes = 0;
        int bad = 0;
        int done_at = -1;
        seed = 8'h20; burst_len = 5'd6;
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            full = (i >= 2 && i <= 4);
            #1;
            if (wr_en && full) bad++;
            if (wr_en) begin
                if (din !== 8'(8'h20 + writes)) bad++;
                writes++;
            end
            if (done) done_at = i;
            step();
        end
        full = 1'b0;
        checks++;
        if (writes != 6 || bad != 0) begin
            failures++;
            $display("FAIL stall_writes got=%0d bad=%0d exp=6 bad=0",
                     writes, bad);
        end
        checks++;
        if (done_at != 9) begin
            failures++;
            $display("FAIL stall_done_cycle got=%0d exp=9", done_at);
        end
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL stall_err got=%b exp=0", err_timeout);
        end
    endtask

    task automatic test_timeout();
        int writes = 0;
        int done_at = -1;
        logic err_at_done = 1'b0;
        full = 1'b1; seed = 8'h00; burst_len = 5'd5;
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            #1;
            if (wr_en) writes++;
            if (done) begin
                done_at = i;
                err_at_done = err_timeout;
            end
            step();
        end
        checks++;
        if (done_at != 17) begin
            failures++;
            $display("FAIL timeout_done_cycle got=%0d exp=17", done_at);
        end
        checks++;
        if (err_at_done !== 1'b1 || writes != 0) begin
            failures++;
            $display("FAIL timeout_err got=%b/%0d exp=1/0",
                     err_at_done, writes);
        end
        full = 1'b0; empty = 1'b1;
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        #1;
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_clear got=%b/%b exp=0/1",
                     err_timeout, busy);
        end
        step(); step(); step();
    endtask

    task automatic test_drain();
        int reads = 0;
        int bad = 0;
        int done_at = -1;
        empty = 1'b0;
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            empty = (i >= 5);
            #1;
            if ((rd_en && empty) || wr_en) bad++;
            if (rd_en) reads++;
            if (done) done_at = i;
            step();
        end
        checks++;
        if (reads != 5 || bad != 0 || done_at != 6) begin
            failures++;
            $display("FAIL drain5 got=%0d/%0d/%0d exp=5/0/6",
                     reads, bad, done_at);
        end
        checks++;
        if (rd_count !== 8'd5) begin
            failures++;
            $display("FAIL drain5_count got=%0d exp=5", rd_count);
        end
        empty = 1'b1;
        reads = 0; done_at = -1;
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        for (int i = 0; i < 10 && done_at < 0; i++) begin
            #1;
            if (rd_en) reads++;
            if (done) done_at = i;
            step();
        end
        checks++;
        if (reads != 0 || done_at != 1 || rd_count !== 8'd0) begin
            failures++;
            $display("FAIL drain_empty got=%0d/%0d/%0d exp=0/1/0",
                     reads, done_at, rd_count);
        end
    endtask

    task automatic test_collision();
        int writes = 0;
        int reads = 0;
        int rej = 0;
        int done_at = -1;
        logic rej1 = 1'b0;
        seed = 8'h10; burst_len = 5'd3; full = 0; empty = 0;
        fill_req = 1'b1; drain_req = 1'b1;
        step();
        fill_req = 1'b0;
        for (int i = 0; i < 10 && done_at < 0; i++) begin
            drain_req = (i == 0);
            #1;
            if (wr_en) writes++;
            if (rd_en) reads++;
            if (i == 1) rej1 = reject;
            else if (reject) rej++;
            if (done) done_at = i;
            step();
        end
        drain_req = 1'b0; empty = 1'b1;
        checks++;
        if (writes != 3 || reads != 0 || done_at != 3) begin
            failures++;
            $display("FAIL collide_fill got=%0d/%0d/%0d exp=3/0/3",
                     writes, reads, done_at);
        end
        checks++;
        if (rej1 !== 1'b1 || rej != 0) begin
            failures++;
            $display("FAIL collide_reject got=%b/%0d exp=1/0", rej1, rej);
        end
        checks++;
        if (wr_count !== 5'd3) begin
            failures++;
            $display("FAIL collide_count got=%0d exp=3", wr_count);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        seed = 8'h00; burst_len = 5'd8; full = 0;
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        step();
        #1;
        checks++;
        if (wr_en !== 1'b1 || din !== 8'h01) begin
            failures++;
            $display("FAIL rstmid_pre got=%b/%h exp=1/01", wr_en, din);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || wr_count !== 5'd0) begin
            failures++;
            $display("FAIL rstmid_drop got=%b/%b/%0d exp=0/0/0",
                     wr_en, busy, wr_count);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (done || wr_en) dones++;
            step();
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rstmid_nodone got=%0d exp=0", dones);
        end
    endtask

    task automatic test_zero_len();
        seed = 8'h55; burst_len = 5'd0; full = 0;
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_first got=%b/%b/%b exp=0/1/0",
                     wr_en, busy, done);
        end
        step();
        #1;
        checks++;
        if (done !== 1'b1 || wr_en !== 1'b0 || wr_count !== 5'd0) begin
            failures++;
            $display("FAIL zero_done got=%b/%b/%0d exp=1/0/0",
                     done, wr_en, wr_count);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_fill_stall();
        test_timeout();
        test_drain();
        test_collision();
        test_reset_mid();
        test_zero_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
